vec_dot_accum: RTL and testbench
================================

Name: vec_dot_accum

Overview:
- Streaming signed SIMD dot-product accumulator; sits directly upstream of the pipelined ReLU stage.
- Each input beat carries LANES pairs of signed DATA_W operands.
- Accumulates lane products across beats until in_last is accepted.
- Emits one 16-bit signed, shifted and saturated result per vector over a valid/ready handshake; the ReLU stage consumes that result.

Parameters:
- DATA_W, 8: signed operand width per lane.
- LANES, 4: operand pairs per beat.
- ACC_W, 24: accumulator width, two's complement, wraps modulo 2^ACC_W.
- OUT_SHIFT, 0: arithmetic right shift applied to the final accumulator before saturation; range 0..ACC_W-16.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts a beat.
- in_a  in  LANES*DATA_W  lane operands A; lane i = bits [i*DATA_W +: DATA_W], signed.
- in_b  in  LANES*DATA_W  lane operands B; same packing as in_a.
- in_last  in  1  final beat of vector; qualified by in_valid && in_ready.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  16  signed result.
- out_sat  out  1  result was clamped.

Behaviour:
- Beat accepted iff in_valid && in_ready. Result handshake iff out_valid && out_ready.
- Product-sum stage:
  - psum = sum over lanes of sign-extended a_i*b_i, computed at width ACC_W.
  - On an accepted beat: psum_reg <= psum and psum_v <= 1. Otherwise psum_v <= 0.
- FSM states: ACC, FLUSH, RESULT. Reset state is ACC.
- ACC:
  - in_ready = 1.
  - Every cycle, if psum_v, acc <= acc + psum_reg.
  - An accepted beat with in_last moves the FSM to FLUSH.
- FLUSH (exactly 1 cycle):
  - in_ready = 0.
  - final = acc + (psum_v ? psum_reg : 0).
  - sh = final >>> OUT_SHIFT.
  - out_data <= clamp(sh, -32768, 32767).
  - out_sat <= (sh was outside that range).
  - psum_v <= 0. Next state RESULT.
- RESULT:
  - in_ready = 0; out_valid = 1; out_data and out_sat held stable.
  - On handshake: acc <= 0, then ACC.
- Latency: last beat accepted at cycle t; out_valid high from cycle t+2.
- Minimum vector is one beat (in_last on the first beat).
- Throughput: one vector per (beats + 2) cycles when out_ready is held high.
- in_valid gaps in ACC are legal:
  - any pending psum is folded into acc;
  - the result is unaffected.
- in_last with in_valid low is ignored.
- in_a and in_b may change freely when no beat is accepted.
- Accumulator overflow wraps silently. Saturation applies only at the output.
- Reset values (asynchronous reset, any time, including mid-vector or in RESULT):
  - state = ACC, acc = 0, psum_reg = 0, psum_v = 0;
  - out_valid = 0, out_data = 0, out_sat = 0;
  - in_ready = 1 once reset is deasserted.
  - A partial vector is discarded.

Optional Feature:
- Macro VEC_DOT_ROUND_EN.
- Defined: the shift rounds half-up, sh = (final + (1 << (OUT_SHIFT-1))) >>> OUT_SHIFT when OUT_SHIFT > 0. The add is performed at ACC_W+1 bits, so it cannot wrap.
- Undefined: plain arithmetic shift, which truncates toward negative infinity.
- OUT_SHIFT = 0 gives identical behaviour either way.

Decomposition:
- Package vec_dot_pkg holds:
  - state enum {ACC, FLUSH, RESULT};
  - OUT_W = 16 and the saturation limits SAT_MAX = 32767 and SAT_MIN = -32768;
  - a clamp-and-flag function for the saturation step.
- One sub-module, vec_dot_psum: the lane multipliers, adder tree and the psum_reg/psum_v register.
- The top level holds the FSM, accumulator and output register.

Test Plan (LANES = 4, DATA_W = 8, OUT_SHIFT = 0 unless stated):
1. Single beat a = {1,2,3,4}, b = {5,6,7,8}, in_last = 1 -> out_valid at t+2, out_data = 70, out_sat = 0.
2. Three beats, all lanes 127*127, with in_valid low for 2 cycles between beats -> sum 193548, out_data = 32767, out_sat = 1.
3. Two beats, all lanes a = -128, b = 127 -> sum -130048, out_data = -32768, out_sat = 1. Next vector a = {-1,0,0,0}, b = {3,0,0,0} -> out_data = -3, out_sat = 0, confirming acc was cleared.
4. Hold out_ready low 5 cycles after out_valid:
   - out_data and out_valid stay stable and in_ready = 0;
   - beats presented during those cycles are not accepted;
   - after the handshake the next vector starts from 0.
5. OUT_SHIFT = 2, single-beat sums -5 and 6:
   - VEC_DOT_ROUND_EN undefined -> -2 and 1;
   - VEC_DOT_ROUND_EN defined -> -1 and 2.
6. Assert rst_n low after the second of three beats, and again while in RESULT -> all outputs zero, in_ready = 1 after release. A fresh single-beat vector gives the correct result (case 1 stimulus -> 70).

Source files
------------

// File: rtl/vec_dot_pkg.sv
// vec_dot_pkg: shared types, constants and the output saturation helper
// for the vec_dot_accum streaming dot-product accumulator.
//   state_t    : FSM encoding (ACC, FLUSH, RESULT)
//   OUT_W      : result width (16)
//   SAT_MAX/MIN: signed 16-bit saturation limits
//   sat_clamp(): clamps a wide signed value to OUT_W bits and flags clamping
package vec_dot_pkg;

    typedef enum logic [1:0] {
        ACC,
        FLUSH,
        RESULT
    } state_t;

    localparam int OUT_W   = 16;
    localparam int SAT_MAX = 32767;
    localparam int SAT_MIN = -32768;

    typedef struct packed {
        logic signed [OUT_W-1:0] data;
        logic                    sat;
    } sat_res_t;

    // Callers sign-extend their value to 64 bits before calling.
    function automatic sat_res_t sat_clamp(input logic signed [63:0] v);
        sat_res_t r;
        if (v > 64'(SAT_MAX)) begin
            r.data = OUT_W'(SAT_MAX);
            r.sat  = 1'b1;
        end else if (v < 64'(SAT_MIN)) begin
            r.data = OUT_W'(SAT_MIN);
            r.sat  = 1'b1;
        end else begin
            r.data = v[OUT_W-1:0];
            r.sat  = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/vec_dot_accum_psum.sv
// vec_dot_psum: lane multipliers, adder tree and the registered beat sum.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   beat_acc        : a beat is accepted this cycle
//   in_a, in_b      : LANES packed signed DATA_W operands
//   psum_reg        : registered sum of lane products (ACC_W, two's complement)
//   psum_v          : psum_reg holds the sum of a beat accepted last cycle
module vec_dot_psum #(
    parameter int DATA_W = 8,
    parameter int LANES  = 4,
    parameter int ACC_W  = 24
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      beat_acc,
    input  logic [LANES*DATA_W-1:0]   in_a,
    input  logic [LANES*DATA_W-1:0]   in_b,
    output logic [ACC_W-1:0]          psum_reg,
    output logic                      psum_v
);
    import vec_dot_pkg::*;

    localparam int PW = 2 * DATA_W;

    logic signed [DATA_W-1:0] a_l;
    logic signed [DATA_W-1:0] b_l;
    logic signed [PW-1:0]     prod;
    logic signed [ACC_W-1:0]  psum_c;

    always_comb begin
        a_l    = '0;
        b_l    = '0;
        prod   = '0;
        psum_c = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            a_l    = in_a[i*DATA_W +: DATA_W];
            b_l    = in_b[i*DATA_W +: DATA_W];
            prod   = PW'(a_l) * PW'(b_l);
            psum_c = psum_c + ACC_W'(prod);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psum_reg <= '0;
            psum_v   <= 1'b0;
        end else begin
            psum_v <= beat_acc;
            if (beat_acc) begin
                psum_reg <= psum_c;
            end
        end
    end

endmodule

// File: rtl/vec_dot_accum.sv
// vec_dot_accum: streaming signed SIMD dot-product accumulator.
// Accumulates LANES products per beat until in_last, then emits one
// shifted, saturated 16-bit result over a valid/ready handshake.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready    : input beat handshake
//   in_a, in_b           : packed signed lane operands
//   in_last              : final beat of the vector
//   out_valid/out_ready  : result handshake
//   out_data             : signed 16-bit result
//   out_sat              : result was clamped
// Build option: define VEC_DOT_ROUND_EN to round the output shift half-up
// instead of truncating toward negative infinity.
module vec_dot_accum #(
    parameter int DATA_W    = 8,
    parameter int LANES     = 4,
    parameter int ACC_W     = 24,
    parameter int OUT_SHIFT = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*DATA_W-1:0]  in_a,
    input  logic [LANES*DATA_W-1:0]  in_b,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [15:0]              out_data,
    output logic                     out_sat
);
    import vec_dot_pkg::*;

    state_t                  state;
    logic signed [ACC_W-1:0] acc;
    logic [ACC_W-1:0]        psum_reg;
    logic                    psum_v;
    logic                    beat_acc;

    logic signed [ACC_W-1:0] fin;
    logic signed [ACC_W:0]   fin_ext;
    logic signed [ACC_W:0]   rnd;
    logic signed [ACC_W:0]   sh;
    sat_res_t                sat_r;

    // in_ready is a registered copy of (state == ACC).
    assign beat_acc = in_valid && in_ready;

    vec_dot_psum #(
        .DATA_W (DATA_W),
        .LANES  (LANES),
        .ACC_W  (ACC_W)
    ) u_psum (
        .clk      (clk),
        .rst_n    (rst_n),
        .beat_acc (beat_acc),
        .in_a     (in_a),
        .in_b     (in_b),
        .psum_reg (psum_reg),
        .psum_v   (psum_v)
    );

`ifdef VEC_DOT_ROUND_EN
    // Half of one output LSB; zero when OUT_SHIFT is 0.
    localparam logic signed [ACC_W:0] RND_ADD = ((ACC_W+1)'(1) << OUT_SHIFT) >> 1;
`endif

    // Final value folds in the last beat's sum still sitting in psum_reg;
    // the shift runs one bit wider so rounding can never wrap.
    always_comb begin
        fin     = acc + (psum_v ? psum_reg : '0);
        fin_ext = {fin[ACC_W-1], fin};
`ifdef VEC_DOT_ROUND_EN
        rnd     = fin_ext + RND_ADD;
`else
        rnd     = fin_ext;
`endif
        sh      = rnd >>> OUT_SHIFT;
        sat_r   = sat_clamp(64'(sh));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACC;
            acc       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else begin
            case (state)
                ACC: begin
                    if (psum_v) begin
                        acc <= acc + psum_reg;
                    end
                    if (beat_acc && in_last) begin
                        state    <= FLUSH;
                        in_ready <= 1'b0;
                    end
                end
                FLUSH: begin
                    out_data  <= sat_r.data;
                    out_sat   <= sat_r.sat;
                    out_valid <= 1'b1;
                    state     <= RESULT;
                end
                RESULT: begin
                    if (out_ready) begin
                        acc       <= '0;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ACC;
                    end
                end
                default: begin
                    state    <= ACC;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vec_dot_accum.sv
// tb_vec_dot_accum: randomized and directed bench for vec_dot_accum.
// Two instances share the input stream: OUT_SHIFT = 0 and OUT_SHIFT = 2.
module tb_vec_dot_accum;

    localparam int DATA_W = 8;
    localparam int LANES  = 4;
    localparam int ACC_W  = 24;
    localparam int MAXB   = 140;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    in_valid = 1'b0;
    logic [LANES*DATA_W-1:0] in_a = '0;
    logic [LANES*DATA_W-1:0] in_b = '0;
    logic                    in_last = 1'b0;
    logic                    out_ready = 1'b0;

    logic                    in_ready0, out_valid0, out_sat0;
    logic signed [15:0]      out_data0;
    logic                    in_ready2, out_valid2, out_sat2;
    logic signed [15:0]      out_data2;

    int total = 0;
    int bad   = 0;

    int va [MAXB][LANES];
    int vb [MAXB][LANES];

    always #5 clk = ~clk;

    vec_dot_accum #(
        .DATA_W(DATA_W), .LANES(LANES), .ACC_W(ACC_W), .OUT_SHIFT(0)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(out_valid0),
        .out_ready(out_ready), .out_data(out_data0), .out_sat(out_sat0)
    );

    vec_dot_accum #(
        .DATA_W(DATA_W), .LANES(LANES), .ACC_W(ACC_W), .OUT_SHIFT(2)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(out_valid2),
        .out_ready(out_ready), .out_data(out_data2), .out_sat(out_sat2)
    );

    task automatic check_val(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: exact integer dot product, wrapped to ACC_W bits,
    // shifted (floor or round-half-up), then clamped to 16 bits.
    function automatic int model_out(input int n, input int shift, output bit sat);
        longint s;
        s = 0;
        for (int b = 0; b < n; b++)
            for (int l = 0; l < LANES; l++)
                s += longint'(va[b][l]) * longint'(vb[b][l]);
        s = s & ((64'sd1 <<< ACC_W) - 1);
        if (s >= (64'sd1 <<< (ACC_W - 1))) s -= (64'sd1 <<< ACC_W);
`ifdef VEC_DOT_ROUND_EN
        if (shift > 0) s += (64'sd1 <<< (shift - 1));
`endif
        s = s >>> shift;
        sat = 1'b0;
        if (s > 32767) begin
            sat = 1'b1;
            s = 32767;
        end else if (s < -32768) begin
            sat = 1'b1;
            s = -32768;
        end
        return int'(s);
    endfunction

    task automatic set_beat(input int b, input int a0, input int a1, input int a2, input int a3,
                            input int b0, input int b1, input int b2, input int b3);
        va[b][0] = a0; va[b][1] = a1; va[b][2] = a2; va[b][3] = a3;
        vb[b][0] = b0; vb[b][1] = b1; vb[b][2] = b2; vb[b][3] = b3;
    endtask

    task automatic fill_const(input int n, input int av, input int bv);
        for (int b = 0; b < n; b++)
            for (int l = 0; l < LANES; l++) begin
                va[b][l] = av;
                vb[b][l] = bv;
            end
    endtask

    task automatic fill_rand(input int n);
        for (int b = 0; b < n; b++)
            for (int l = 0; l < LANES; l++) begin
                va[b][l] = int'($urandom_range(0, 255)) - 128;
                vb[b][l] = int'($urandom_range(0, 255)) - 128;
            end
    endtask

    task automatic drive_beat(input int b);
        int av, bv;
        for (int l = 0; l < LANES; l++) begin
            av = va[b][l];
            bv = vb[b][l];
            in_a[l*DATA_W +: DATA_W] = av[DATA_W-1:0];
            in_b[l*DATA_W +: DATA_W] = bv[DATA_W-1:0];
        end
    endtask

    task automatic junk();
        in_a    = $urandom;
        in_b    = $urandom;
        in_last = 1'($urandom);
    endtask

    // gap < 0: random 0..2 idle cycles between beats.
    task automatic do_vector(input int n, input int gap, input int stall, input bit hs,
                             input string tag);
        int e0, e2, g, cnt;
        bit s0, s2;
        e0 = model_out(n, 0, s0);
        e2 = model_out(n, 2, s2);
        for (int b = 0; b < n; b++) begin
            check_val({tag, ".rdy"}, int'(in_ready0), 1);
            check_val({tag, ".rdy2"}, int'(in_ready2), 1);
            drive_beat(b);
            in_valid = 1'b1;
            in_last  = (b == n - 1);
            tick();
            in_valid = 1'b0;
            junk();
            if (b != n - 1) begin
                g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
                repeat (g) tick();
            end
        end
        check_val({tag, ".flush_vld"}, int'(out_valid0), 0);
        check_val({tag, ".flush_rdy"}, int'(in_ready0), 0);
        tick();
        cnt = 0;
        while (!out_valid0 && cnt < 20) begin
            tick();
            cnt++;
        end
        check_val({tag, ".lat"}, cnt, 0);
        check_val({tag, ".vld2"}, int'(out_valid2), 1);
        check_val({tag, ".data"}, int'(out_data0), e0);
        check_val({tag, ".sat"}, int'(out_sat0), int'(s0));
        check_val({tag, ".data_sh2"}, int'(out_data2), e2);
        check_val({tag, ".sat_sh2"}, int'(out_sat2), int'(s2));
        for (int k = 0; k < stall; k++) begin
            in_valid = 1'b1;
            junk();
            tick();
            check_val({tag, ".stall_vld"}, int'(out_valid0), 1);
            check_val({tag, ".stall_rdy"}, int'(in_ready0), 0);
            check_val({tag, ".stall_data"}, int'(out_data0), e0);
        end
        in_valid = 1'b0;
        if (hs) begin
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            check_val({tag, ".hs_vld"}, int'(out_valid0), 0);
            check_val({tag, ".hs_rdy"}, int'(in_ready0), 1);
        end
    endtask

    task automatic check_reset_outs(input string tag);
        check_val({tag, ".vld"}, int'(out_valid0), 0);
        check_val({tag, ".data"}, int'(out_data0), 0);
        check_val({tag, ".sat"}, int'(out_sat0), 0);
        check_val({tag, ".rdy"}, int'(in_ready0), 1);
        check_val({tag, ".data2"}, int'(out_data2), 0);
    endtask

    task automatic pulse_reset(input string tag);
        rst_n = 1'b0;
        #2;
        check_reset_outs(tag);
        tick();
        rst_n = 1'b1;
        tick();
        check_val({tag, ".rdy_rel"}, int'(in_ready0), 1);
        check_val({tag, ".vld_rel"}, int'(out_valid0), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset_outs("reset");
        rst_n = 1'b1;
        tick();
        check_val("reset.rdy_rel", int'(in_ready0), 1);

        set_beat(0, 1, 2, 3, 4, 5, 6, 7, 8);
        do_vector(1, 0, 0, 1'b1, "c1");

        fill_const(3, 127, 127);
        do_vector(3, 2, 0, 1'b1, "c2");

        fill_const(2, -128, 127);
        do_vector(2, 0, 0, 1'b1, "c3a");
        set_beat(0, -1, 0, 0, 0, 3, 0, 0, 0);
        do_vector(1, 0, 0, 1'b1, "c3b");

        fill_rand(4);
        do_vector(4, 1, 5, 1'b1, "c4a");
        set_beat(0, 1, 2, 3, 4, 5, 6, 7, 8);
        do_vector(1, 0, 0, 1'b1, "c4b");

        set_beat(0, -5, 0, 0, 0, 1, 0, 0, 0);
        do_vector(1, 0, 0, 1'b1, "c5a");
        set_beat(0, 6, 0, 0, 0, 1, 0, 0, 0);
        do_vector(1, 0, 0, 1'b1, "c5b");

        fill_const(130, -128, -128);
        do_vector(130, 0, 0, 1'b1, "wrap");

        fill_const(3, 100, -77);
        for (int b = 0; b < 2; b++) begin
            drive_beat(b);
            in_valid = 1'b1;
            in_last  = 1'b0;
            tick();
            in_valid = 1'b0;
        end
        pulse_reset("c6mid");
        set_beat(0, 1, 2, 3, 4, 5, 6, 7, 8);
        do_vector(1, 0, 0, 1'b1, "c6a");

        fill_const(2, 90, 90);
        do_vector(2, 0, 0, 1'b0, "c6r");
        pulse_reset("c6res");
        set_beat(0, 1, 2, 3, 4, 5, 6, 7, 8);
        do_vector(1, 0, 0, 1'b1, "c6b");

        for (int v = 0; v < 20; v++) begin
            int n;
            n = int'($urandom_range(1, 6));
            fill_rand(n);
            do_vector(n, -1, int'($urandom_range(0, 3)), 1'b1, "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
